// File: rtl/axi_bridge_arb_pkg.sv
// Shared AXI constants, default IDs, FSM encodings and the latched request record
// for the icache/dcache to AXI3 bridge arbiter.
package axi_bridge_arb_pkg;

    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [3:0] ID_I_DEF = 4'd0;
    localparam logic [3:0] ID_D_DEF = 4'd1;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
    } req_t;

endpackage

// File: rtl/axi_bridge_arb_if.sv
// Signal bundle between the caches, the bridge and the SoC crossbar.
// The master modport is the bridge view; slave is the cache/crossbar environment view.
interface axi_bridge_arb_if;

    logic [31:0] i_araddr;
    logic [3:0]  i_arlen;
    logic        i_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_rlast;

    logic [31:0] d_araddr;
    logic [3:0]  d_arlen;
    logic        d_arvalid;
    logic        d_arready;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rlast;

    logic [31:0] d_awaddr;
    logic [3:0]  d_awlen;
    logic        d_awvalid;
    logic        d_awready;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_wvalid;
    logic        d_wlast;
    logic        d_wready;
    logic        d_bvalid;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic        rlast_err;

    modport master (
        input  i_araddr, i_arlen, i_arvalid,
        input  d_araddr, d_arlen, d_arvalid,
        input  d_awaddr, d_awlen, d_awvalid, d_wdata, d_wstrb, d_wvalid, d_wlast,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid,
        output i_arready, i_rdata, i_rvalid, i_rlast,
        output d_arready, d_rdata, d_rvalid, d_rlast,
        output d_awready, d_wready, d_bvalid,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        output rlast_err
    );

    modport slave (
        output i_araddr, i_arlen, i_arvalid,
        output d_araddr, d_arlen, d_arvalid,
        output d_awaddr, d_awlen, d_awvalid, d_wdata, d_wstrb, d_wvalid, d_wlast,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid,
        input  i_arready, i_rdata, i_rvalid, i_rlast,
        input  d_arready, d_rdata, d_rvalid, d_rlast,
        input  d_awready, d_wready, d_bvalid,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        input  rlast_err
    );

endinterface

// File: rtl/axi_bridge_arb.sv
// Arbitrates icache/dcache onto one AXI3 master: AR/AW one cycle after request, R/W/B forwarded
// combinationally; one read and one write outstanding, requesters wait (not dropped) while busy.
module axi_bridge_arb
    import axi_bridge_arb_pkg::*;
#(
    parameter logic [3:0] ID_I = ID_I_DEF,
    parameter logic [3:0] ID_D = ID_D_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    axi_bridge_arb_if.master bus
);

    rd_state_t rd_state_q, rd_state_d;
    logic      rd_gnt_q, rd_gnt_d;          // 1: dcache owns the read channel
    req_t      rd_req_q, rd_req_d;
    logic [3:0] beat_q, beat_d;
    logic      rlast_err_q, rlast_err_d;

    wr_state_t wr_state_q, wr_state_d;
    req_t      wr_req_q, wr_req_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q  <= R_IDLE;
            rd_gnt_q    <= 1'b0;
            rd_req_q    <= '0;
            beat_q      <= '0;
            rlast_err_q <= 1'b0;
            wr_state_q  <= W_IDLE;
            wr_req_q    <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_gnt_q    <= rd_gnt_d;
            rd_req_q    <= rd_req_d;
            beat_q      <= beat_d;
            rlast_err_q <= rlast_err_d;
            wr_state_q  <= wr_state_d;
            wr_req_q    <= wr_req_d;
        end
    end

    // Read channel: dcache wins ties; R beats are steered only to the granted cache.
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_gnt_d      = rd_gnt_q;
        rd_req_d      = rd_req_q;
        beat_d        = beat_q;
        rlast_err_d   = rlast_err_q;
        bus.arvalid   = 1'b0;
        bus.rready    = 1'b0;
        bus.i_arready = 1'b0;
        bus.d_arready = 1'b0;
        bus.i_rdata   = '0;
        bus.i_rvalid  = 1'b0;
        bus.i_rlast   = 1'b0;
        bus.d_rdata   = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rlast   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (bus.d_arvalid) begin
                    rd_gnt_d   = 1'b1;
                    rd_req_d   = '{addr: bus.d_araddr, len: bus.d_arlen};
                    rd_state_d = R_ADDR;
                end else if (bus.i_arvalid) begin
                    rd_gnt_d   = 1'b0;
                    rd_req_d   = '{addr: bus.i_araddr, len: bus.i_arlen};
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    bus.i_arready = ~rd_gnt_q;
                    bus.d_arready = rd_gnt_q;
                    beat_d        = '0;
                    rd_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                bus.rready = 1'b1;
                if (rd_gnt_q) begin
                    bus.d_rdata  = bus.rdata;
                    bus.d_rvalid = bus.rvalid;
                    bus.d_rlast  = bus.rlast;
                end else begin
                    bus.i_rdata  = bus.rdata;
                    bus.i_rvalid = bus.rvalid;
                    bus.i_rlast  = bus.rlast;
                end
                if (bus.rvalid) begin
                    beat_d = beat_q + 4'd1;
                    if (bus.rlast) begin
                        // beat_q still holds the index of this final beat
                        if (beat_q != rd_req_q.len) begin
                            rlast_err_d = 1'b1;
                        end
                        rd_state_d = R_IDLE;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d    = wr_state_q;
        wr_req_d      = wr_req_q;
        bus.awvalid   = 1'b0;
        bus.d_awready = 1'b0;
        bus.wvalid    = 1'b0;
        bus.wdata     = '0;
        bus.wstrb     = '0;
        bus.wlast     = 1'b0;
        bus.d_wready  = 1'b0;
        bus.bready    = 1'b0;
        bus.d_bvalid  = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (bus.d_awvalid) begin
                    wr_req_d   = '{addr: bus.d_awaddr, len: bus.d_awlen};
                    wr_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                bus.awvalid = 1'b1;
                if (bus.awready) begin
                    bus.d_awready = 1'b1;
                    wr_state_d    = W_DATA;
                end
            end
            W_DATA: begin
                bus.wvalid   = bus.d_wvalid;
                bus.wdata    = bus.d_wdata;
                bus.wstrb    = bus.d_wstrb;
                bus.wlast    = bus.d_wlast;
                bus.d_wready = bus.wready;
                if (bus.d_wvalid && bus.wready && bus.d_wlast) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    bus.d_bvalid = 1'b1;
                    wr_state_d   = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign bus.arid    = rd_gnt_q ? ID_D : ID_I;
    assign bus.araddr  = rd_req_q.addr;
    assign bus.arlen   = rd_req_q.len;
    assign bus.arsize  = SIZE_WORD;
    assign bus.arburst = BURST_INCR;
    assign bus.arlock  = '0;
    assign bus.arcache = '0;
    assign bus.arprot  = '0;

    assign bus.awid    = ID_D;
    assign bus.awaddr  = wr_req_q.addr;
    assign bus.awlen   = wr_req_q.len;
    assign bus.awsize  = SIZE_WORD;
    assign bus.awburst = BURST_INCR;
    assign bus.awlock  = '0;
    assign bus.awcache = '0;
    assign bus.awprot  = '0;
    assign bus.wid     = ID_D;

    assign bus.rlast_err = rlast_err_q;

    // Single outstanding transaction per direction, so IDs and responses are not inspected.
    logic unused_resp;
    assign unused_resp = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

endmodule
